sevenseg_scanner: RTL and testbench

Parametrised, time-multiplexed seven-segment display driver for the board debug display. It scans `N_DIGITS` common-anode digits, decodes 4-bit hex nibbles to segments, and adds per-digit blanking, decimal points, leading-zero suppression, PWM brightness and a one-cycle anti-ghosting dead time. The block sits between the processor's display/LED register and the board pins, and it replaces the fixed 8-way combinational anode decoder.

---
 rtl/seg_pkg.sv | 29 ++
 rtl/sevenseg_scanner_if.sv | 27 ++
 rtl/sevenseg_scanner_decoder.sv | 9 +
 rtl/sevenseg_scanner.sv | 124 ++++++++++++
 tb/tb_sevenseg_scanner.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared glyph types, the hex glyph table and the leading-zero mask helper
// for the seven-segment scanner.
package seg_pkg;

    typedef logic [6:0] seg_t;  // {g,f,e,d,c,b,a}, active-low

    localparam seg_t SEG_BLANK = 7'h7F;

    localparam seg_t SEG_HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Bit k set when digit k (k >= 1) and every more-significant digit is zero.
    function automatic logic [15:0] lz_mask(input logic [63:0] data, input int n);
        logic [15:0] mask;
        logic        all_zero;
        mask     = '0;
        all_zero = 1'b1;
        for (int k = 15; k >= 1; k--) begin
            if (k < n) begin
                all_zero = all_zero && (data[4*k +: 4] == 4'h0);
                mask[k]  = all_zero;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/sevenseg_scanner_if.sv
// Register-side controls and pin-side outputs of the seven-segment scanner.
// Controls are sampled every clock; outputs are registered, no handshake.
interface sevenseg_scanner_if #(
    parameter int N_DIGITS = 8,
    parameter int BRIGHT_W = 4
);
    logic                    en;
    logic [4*N_DIGITS-1:0]   data;
    logic [N_DIGITS-1:0]     dp;
    logic [N_DIGITS-1:0]     blank;
    logic                    lz_suppress;
    logic [BRIGHT_W-1:0]     brightness;
    logic [N_DIGITS-1:0]     ss_sel;
    logic [6:0]              seg;
    logic                    dp_n;
    logic                    frame_done;

    modport master (
        output en, data, dp, blank, lz_suppress, brightness,
        input  ss_sel, seg, dp_n, frame_done
    );

    modport slave (
        input  en, data, dp, blank, lz_suppress, brightness,
        output ss_sel, seg, dp_n, frame_done
    );
endinterface

// File: rtl/sevenseg_scanner_decoder.sv
// Combinational hex nibble to active-low seven-segment glyph.
module hex7seg_decoder
    import seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output seg_t       seg_o
);
    assign seg_o = SEG_HEX[nibble_i];
endmodule

// File: rtl/sevenseg_scanner.sv
// Time-multiplexed common-anode display driver: slot/digit/PWM counters,
// frame shadows with leading-zero mask, dead time and registered pin outputs.
module sevenseg_scanner
    import seg_pkg::*;
#(
    parameter int N_DIGITS    = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int BRIGHT_W    = 4
) (
    input logic               clk,
    input logic               rst_n,
    sevenseg_scanner_if.slave bus
);
    localparam int TICK_W = $clog2(REFRESH_DIV);
    localparam int IDX_W  = $clog2(N_DIGITS);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_DIGITS - 1);

    logic [TICK_W-1:0]     tick_q, tick_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [BRIGHT_W-1:0]   pwm_q, pwm_d;
    logic                  en_q;
    logic [4*N_DIGITS-1:0] data_sh_q, data_sh_d;
    logic [N_DIGITS-1:0]   dp_sh_q, dp_sh_d;
    logic [N_DIGITS-1:0]   blank_sh_q, blank_sh_d;
    logic [N_DIGITS-1:0]   lz_sh_q, lz_sh_d;
    logic [N_DIGITS-1:0]   ss_sel_q, ss_sel_d;
    seg_t                  seg_q, seg_d;
    logic                  dp_n_q, dp_n_d;
    logic                  frame_done_q, frame_done_d;

    logic                  slot_end, frame_end, capture, dark, anode_on;
    logic [3:0]            nibble;
    seg_t                  glyph;

    hex7seg_decoder u_dec (
        .nibble_i (nibble),
        .seg_o    (glyph)
    );

    always_comb begin
        slot_end  = (tick_q == TICK_LAST);
        frame_end = slot_end && (idx_q == IDX_LAST);
        // Capture on the first enabled cycle and whenever a frame rolls over.
        capture   = bus.en && (!en_q || frame_end);

        tick_d = '0;
        idx_d  = '0;
        pwm_d  = '0;
        if (bus.en) begin
            tick_d = slot_end ? '0 : tick_q + 1'b1;
            idx_d  = idx_q;
            if (slot_end) begin
                idx_d = frame_end ? '0 : idx_q + 1'b1;
            end
            pwm_d = pwm_q + 1'b1;
        end

        data_sh_d  = data_sh_q;
        dp_sh_d    = dp_sh_q;
        blank_sh_d = blank_sh_q;
        lz_sh_d    = lz_sh_q;
        if (capture) begin
            data_sh_d  = bus.data;
            dp_sh_d    = bus.dp;
            blank_sh_d = bus.blank;
            lz_sh_d    = bus.lz_suppress ? N_DIGITS'(lz_mask(64'(bus.data), N_DIGITS)) : '0;
        end

        nibble   = data_sh_q[{idx_q, 2'b00} +: 4];
        dark     = blank_sh_q[idx_q] | lz_sh_q[idx_q];
        // Tick 0 is the anti-ghosting dead cycle while segments settle.
        anode_on = (tick_q != '0) && (pwm_q < bus.brightness);

        ss_sel_d     = '1;
        seg_d        = SEG_BLANK;
        dp_n_d       = 1'b1;
        frame_done_d = 1'b0;
        if (bus.en) begin
            if (anode_on) begin
                ss_sel_d = ~(N_DIGITS'(1) << idx_q);
            end
            seg_d        = dark ? SEG_BLANK : glyph;
            dp_n_d       = dark | ~dp_sh_q[idx_q];
            frame_done_d = frame_end;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q       <= '0;
            idx_q        <= '0;
            pwm_q        <= '0;
            en_q         <= 1'b0;
            data_sh_q    <= '0;
            dp_sh_q      <= '0;
            blank_sh_q   <= '0;
            lz_sh_q      <= '0;
            ss_sel_q     <= '1;
            seg_q        <= SEG_BLANK;
            dp_n_q       <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            tick_q       <= tick_d;
            idx_q        <= idx_d;
            pwm_q        <= pwm_d;
            en_q         <= bus.en;
            data_sh_q    <= data_sh_d;
            dp_sh_q      <= dp_sh_d;
            blank_sh_q   <= blank_sh_d;
            lz_sh_q      <= lz_sh_d;
            ss_sel_q     <= ss_sel_d;
            seg_q        <= seg_d;
            dp_n_q       <= dp_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.ss_sel     = ss_sel_q;
    assign bus.seg        = seg_q;
    assign bus.dp_n       = dp_n_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_sevenseg_scanner.sv
// Directed bench for sevenseg_scanner with a per-cycle expected-output queue.
module tb_sevenseg_scanner;
    import seg_pkg::*;

    localparam int N   = 4;
    localparam int DIV = 4;
    localparam int BW  = 2;
    localparam int FRAME = N * DIV;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    sevenseg_scanner_if #(.N_DIGITS(N), .BRIGHT_W(BW)) bus ();

    sevenseg_scanner #(
        .N_DIGITS    (N),
        .REFRESH_DIV (DIV),
        .BRIGHT_W    (BW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [6:0] glyph [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [4*N-1:0] m_data;
    logic [N-1:0]   m_dp;
    logic [N-1:0]   m_blank;
    logic           m_lz;

    // {frame_done, dp_n, seg[6:0], ss_sel[3:0]}
    logic [12:0] exp_q[$];

    function automatic logic [12:0] predict();
        int         tick, idx, pwm;
        logic [3:0] sel;
        logic [6:0] s;
        logic       dn, fd, dark, allz;
        if (!bus.en) return {1'b0, 1'b1, 7'h7F, 4'hF};
        tick = cyc % DIV;
        idx  = (cyc / DIV) % N;
        pwm  = cyc % (1 << BW);
        sel  = (tick != 0 && pwm < int'(bus.brightness)) ? ~(4'b0001 << idx) : 4'hF;
        allz = 1'b1;
        for (int k = N - 1; k >= idx; k--) allz = allz && (m_data[4*k +: 4] == 4'h0);
        dark = m_blank[idx] || (m_lz && idx != 0 && allz);
        s    = dark ? 7'h7F : glyph[m_data[4*idx +: 4]];
        dn   = dark ? 1'b1 : !m_dp[idx];
        fd   = ((cyc % FRAME) == FRAME - 1);
        return {fd, dn, s, sel};
    endfunction

    task automatic cycle_check();
        logic [12:0] e;
        if (!bus.en) cyc = 0;
        exp_q.push_back(predict());
        if (bus.en && (cyc == 0 || (cyc % FRAME) == FRAME - 1)) begin
            m_data  = bus.data;
            m_dp    = bus.dp;
            m_blank = bus.blank;
            m_lz    = bus.lz_suppress;
        end
        @(posedge clk);
        if (bus.en) cyc++;
        @(negedge clk);
        e = exp_q.pop_front();
        total++;
        assert (bus.ss_sel === e[3:0]) else begin
            bad++;
            $error("FAIL ss_sel got=%h exp=%h cyc=%0d", bus.ss_sel, e[3:0], cyc);
        end
        total++;
        assert (bus.frame_done === e[12]) else begin
            bad++;
            $error("FAIL frame_done got=%b exp=%b cyc=%0d", bus.frame_done, e[12], cyc);
        end
        if (e[3:0] != 4'hF || !bus.en) begin
            total++;
            assert (bus.seg === e[10:4]) else begin
                bad++;
                $error("FAIL seg got=%h exp=%h cyc=%0d", bus.seg, e[10:4], cyc);
            end
            total++;
            assert (bus.dp_n === e[11]) else begin
                bad++;
                $error("FAIL dp_n got=%b exp=%b cyc=%0d", bus.dp_n, e[11], cyc);
            end
        end
    endtask

    task automatic check_reset(input string tag);
        total++;
        assert (bus.ss_sel === 4'hF) else begin
            bad++;
            $error("FAIL %s_ss_sel got=%h exp=%h", tag, bus.ss_sel, 4'hF);
        end
        total++;
        assert (bus.seg === 7'h7F) else begin
            bad++;
            $error("FAIL %s_seg got=%h exp=%h", tag, bus.seg, 7'h7F);
        end
        total++;
        assert (bus.dp_n === 1'b1) else begin
            bad++;
            $error("FAIL %s_dp_n got=%b exp=1", tag, bus.dp_n);
        end
        total++;
        assert (bus.frame_done === 1'b0) else begin
            bad++;
            $error("FAIL %s_frame_done got=%b exp=0", tag, bus.frame_done);
        end
    endtask

    task automatic clear_model();
        cyc     = 0;
        m_data  = '0;
        m_dp    = '0;
        m_blank = '0;
        m_lz    = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n           = 1'b0;
        bus.en          = 1'b0;
        bus.data        = '0;
        bus.dp          = '0;
        bus.blank       = '0;
        bus.lz_suppress = 1'b0;
        bus.brightness  = '0;
        clear_model();

        // Reset, then held idle with en low
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;
        repeat (8) cycle_check();

        // Scan order, decode and decimal point
        bus.data       = 16'h8A10;
        bus.dp         = 4'b0100;
        bus.brightness = 2'd3;
        bus.en         = 1'b1;
        repeat (2 * FRAME) cycle_check();

        // Leading-zero suppression and blanking
        bus.dp          = '0;
        bus.data        = 16'h0050;
        bus.lz_suppress = 1'b1;
        repeat (2 * FRAME) cycle_check();
        bus.data = 16'h0000;
        repeat (2 * FRAME) cycle_check();
        bus.blank = 4'b0001;
        repeat (2 * FRAME) cycle_check();

        // Mid-frame data change is held off until the next frame
        bus.blank       = '0;
        bus.lz_suppress = 1'b0;
        bus.data        = 16'h1234;
        bus.dp          = 4'b0001;
        repeat (FRAME) cycle_check();
        for (int i = 0; i < FRAME && (cyc % FRAME) != 5; i++) cycle_check();
        bus.data = 16'hBEEF;
        bus.dp   = 4'b1000;
        repeat (2 * FRAME) cycle_check();

        // Brightness extremes
        bus.brightness = 2'd0;
        repeat (2 * FRAME) cycle_check();
        bus.brightness = 2'd1;
        repeat (2 * FRAME) cycle_check();
        bus.brightness = 2'd2;
        repeat (FRAME) cycle_check();
        bus.brightness = 2'd3;

        // Enable drop clears counters, shadows hold, recapture on rise
        bus.en = 1'b0;
        repeat (4) cycle_check();
        bus.data = 16'h8A10;
        bus.dp   = 4'b0010;
        bus.en   = 1'b1;
        repeat (FRAME + 4) cycle_check();

        // Asynchronous reset mid-scan at idx=2, tick=2
        for (int i = 0; i < FRAME && (cyc % FRAME) != 10; i++) cycle_check();
        rst_n = 1'b0;
        #1;
        check_reset("async_rst");
        clear_model();
        repeat (2) @(negedge clk);
        check_reset("rst_hold");
        bus.data = 16'h0F5C;
        bus.dp   = 4'b1001;
        rst_n    = 1'b1;
        repeat (2 * FRAME) cycle_check();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
